mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sits between the pipeline MEM stage and the word-wide data memory.
- Converts lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses: byte enables, lane-replicated write data, aligned address.
- Holds the memory enables until Ack, then extracts and sign/zero-extends read data.
- Stalls the pipeline for the duration of the access and flags misaligned addresses and Ack timeouts.

Parameters:
- TIMEOUT, 15: maximum cycles spent in ACCESS without MemAck before a bus error; counter width is $clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- ReqValid  in  1  MEM stage presents a load/store this cycle
- ReqWrite  in  1  1=store, 0=load
- ReqSize  in  2  0=byte, 1=half, 2=word, 3=reserved
- ReqSigned  in  1  loads only: 1=sign-extend, 0=zero-extend
- ReqAddr  in  32  byte address
- ReqWData  in  32  store data, right-justified
- Stall  out  1  freeze the pipeline
- RespValid  out  1  one-cycle pulse: access complete
- RespData  out  32  extended load data, valid with RespValid
- AddrError  out  1  one-cycle pulse: misaligned or reserved size
- BusError  out  1  one-cycle pulse: Ack timeout
- MemAddress  out  32  {addr[31:2],2'b00}
- MemWriteData  out  32  lane-replicated store data
- MemWriteEnable  out  1  memory write strobe
- MemReadEnable  out  1  memory read strobe
- MemByteEnable  out  4  byte lane enables
- MemAck  in  1  memory completion, registered one cycle after an enable
- MemReadData  in  32  combinational memory read word, valid only while MemReadEnable=1

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0. RST mid-access aborts immediately; enables are low in the next cycle; no response is generated.
- Byte ordering: big-endian lanes, byte offset o=addr[1:0] maps to lane 3-o (bits [31-8o -: 8]).
  - Byte access: BE=4'b0001<<(3-o), data={4{wd[7:0]}}.
  - Half access: BE = 4'b1100 at o=0, 4'b0011 at o=2; data={2{wd[15:0]}}.
  - Word access: BE=4'b1111.
- Alignment check: an error is half with addr[0]=1, word with addr[1:0]!=0, or size 3.
- IDLE:
  - ReqValid with an alignment error: AddrError=1 combinationally this cycle, Stall=0, no memory access, stay IDLE.
  - ReqValid with no error: Stall=1 combinationally; register address, size, signed, write and shifted data/BE; go to ACCESS.
- ACCESS:
  - MemWriteEnable=ReqWrite_r, MemReadEnable=!ReqWrite_r, Stall=1. Enables are held every ACCESS cycle, including the Ack cycle; repeated writes are idempotent.
  - On MemAck=1: capture the extracted and extended MemReadData (loads), go to DONE.
  - Counter increments each ACCESS cycle without Ack. When it reaches TIMEOUT: BusError pulse, go IDLE, no RespValid.
- DONE: RespValid=1, Stall=0, enables low, go IDLE. ReqValid is ignored in DONE because the pipeline still presents the completed request this cycle. For stores, RespData=0.
- Nominal latency: accept at cycle 0, ACCESS cycles 1–2 (Ack seen in cycle 2), DONE at cycle 3. Stall is high in cycles 0–2.
- Extension: byte/half signed fills with the msb of the extracted field; unsigned fills with zeros. Word loads ignore ReqSigned.
- MemAddress, MemWriteData and MemByteEnable are registered and stable for the entire ACCESS period; they are 0 in IDLE.

Test Plan:
- Word read/write: sw 0xDEADBEEF @0x8, then lw @0x8 -> BE=1111 on both; Stall high 3 cycles each; RespValid in cycle 3; RespData=0xDEADBEEF.
- Byte lanes and extension: after the word above, lb @0x9 -> BE=0100, RespData=0xFFFFFFAD; lbu @0xB -> RespData=0x000000EF.
- Half store: sh 0x1234 @0xA -> BE=0011, MemWriteData=0x12341234; then lw @0x8 -> 0xDEAD1234; lh @0x8 -> 0xFFFFDEAD.
- Misalignment: lw @0x6, lh @0x3 and size=3 -> AddrError 1-cycle pulse, Stall=0, enables never asserted, RespValid=0.
- Timeout: tie MemAck=0, lw @0x0 -> enables high for 15 cycles, BusError pulse, return to IDLE, no RespValid.
- Reset mid-access: assert RST during the first ACCESS cycle -> next cycle all enables, Stall and RespValid are 0; a subsequent lw completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the pipeline request/response signals and the word-wide data
// memory bus seen by mem_access_ctrl. The slave view is the controller
// itself; the master view is its environment (MEM stage plus memory).
interface mem_access_ctrl_if;
  // Pipeline request
  logic        ReqValid;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;

  // Pipeline response
  logic        Stall;
  logic        RespValid;
  logic [31:0] RespData;
  logic        AddrError;
  logic        BusError;

  // Data memory bus
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemReadEnable;
  logic [3:0]  MemByteEnable;
  logic        MemAck;
  logic [31:0] MemReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
    input  MemAck, MemReadData,
    output Stall, RespValid, RespData, AddrError, BusError,
    output MemAddress, MemWriteData, MemWriteEnable, MemReadEnable, MemByteEnable
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
    output MemAck, MemReadData,
    input  Stall, RespValid, RespData, AddrError, BusError,
    input  MemAddress, MemWriteData, MemWriteEnable, MemReadEnable, MemByteEnable
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller between the MEM stage and a word-wide data memory.
// Turns byte/half/word loads and stores into big-endian word accesses, holds
// the memory strobes until MemAck, extends load data, and reports misaligned
// requests and acknowledge timeouts.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input logic         CLK,
  input logic         RST,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] count;

  logic        misaligned;
  logic        accept;
  logic [3:0]  be_new;
  logic [31:0] wd_new;

  logic [29:0] word_addr_r;
  logic [3:0]  be_r;
  logic [31:0] wd_r;
  logic [1:0]  size_r;
  logic [1:0]  offset_r;
  logic        signed_r;
  logic        write_r;
  logic [31:0] rdata_r;

  logic [7:0]  byte_field;
  logic [15:0] half_field;
  logic [31:0] load_ext;

  logic stall;
  logic resp_valid;
  logic addr_error;
  logic bus_error;
  logic write_en;
  logic read_en;

  // A request is bad if a half is odd-addressed, a word is not on a word
  // boundary, or the size code is the reserved one.
  always_comb begin
    misaligned = 1'b0;
    case (bus.ReqSize)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.ReqAddr[0];
      2'd2:    misaligned = |bus.ReqAddr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && bus.ReqValid && !misaligned;

  // Big-endian lane placement: offset 0 is the most significant byte lane,
  // and store data is replicated so every lane carries the right bytes.
  always_comb begin
    be_new = 4'b1111;
    wd_new = bus.ReqWData;
    case (bus.ReqSize)
      2'd0: begin
        be_new = 4'b0001 << (2'd3 - bus.ReqAddr[1:0]);
        wd_new = {4{bus.ReqWData[7:0]}};
      end
      2'd1: begin
        be_new = bus.ReqAddr[1] ? 4'b0011 : 4'b1100;
        wd_new = {2{bus.ReqWData[15:0]}};
      end
      default: begin
        be_new = 4'b1111;
        wd_new = bus.ReqWData;
      end
    endcase
  end

  // Pull the addressed byte/half out of the memory word and extend it;
  // word loads pass through untouched regardless of the signed flag.
  always_comb begin
    byte_field = 8'h00;
    half_field = 16'h0000;
    load_ext   = bus.MemReadData;
    case (offset_r)
      2'd0:    byte_field = bus.MemReadData[31:24];
      2'd1:    byte_field = bus.MemReadData[23:16];
      2'd2:    byte_field = bus.MemReadData[15:8];
      default: byte_field = bus.MemReadData[7:0];
    endcase
    half_field = offset_r[1] ? bus.MemReadData[15:0] : bus.MemReadData[31:16];
    case (size_r)
      2'd0:    load_ext = signed_r ? {{24{byte_field[7]}}, byte_field}
                                   : {24'h000000, byte_field};
      2'd1:    load_ext = signed_r ? {{16{half_field[15]}}, half_field}
                                   : {16'h0000, half_field};
      default: load_ext = bus.MemReadData;
    endcase
  end

  // State register; reset anywhere (including mid-access) returns to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and strobe/handshake decode; enables are held through the
  // Ack cycle since a repeated write of the same data is harmless.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    resp_valid = 1'b0;
    addr_error = 1'b0;
    bus_error  = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ReqValid) begin
          if (misaligned) begin
            addr_error = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall    = 1'b1;
        write_en = write_r;
        read_en  = !write_r;
        if (bus.MemAck) begin
          state_next = DONE;
        end else if (count == CNT_LAST) begin
          bus_error  = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counts ACCESS cycles without Ack; cleared whenever the access ends.
  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (state == ACCESS && state_next == ACCESS)
      count <= count + 1'b1;
    else
      count <= '0;
  end

  // Capture the request on acceptance; bus-facing copies are zeroed outside ACCESS.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_addr_r <= '0;
      be_r        <= '0;
      wd_r        <= '0;
      size_r      <= '0;
      offset_r    <= '0;
      signed_r    <= 1'b0;
      write_r     <= 1'b0;
    end else if (accept) begin
      word_addr_r <= bus.ReqAddr[31:2];
      be_r        <= be_new;
      wd_r        <= wd_new;
      size_r      <= bus.ReqSize;
      offset_r    <= bus.ReqAddr[1:0];
      signed_r    <= bus.ReqSigned;
      write_r     <= bus.ReqWrite;
    end else if (state_next != ACCESS) begin
      word_addr_r <= '0;
      be_r        <= '0;
      wd_r        <= '0;
    end
  end

  // Latch the extended load word in the Ack cycle; stores report zero.
  always_ff @(posedge CLK) begin
    if (RST)
      rdata_r <= '0;
    else if (state == ACCESS && bus.MemAck)
      rdata_r <= write_r ? 32'h0000_0000 : load_ext;
  end

  assign bus.Stall          = stall;
  assign bus.RespValid      = resp_valid;
  assign bus.RespData       = (state == DONE) ? rdata_r : 32'h0000_0000;
  assign bus.AddrError      = addr_error;
  assign bus.BusError       = bus_error;
  assign bus.MemAddress     = {word_addr_r, 2'b00};
  assign bus.MemWriteData   = wd_r;
  assign bus.MemWriteEnable = write_en;
  assign bus.MemReadEnable  = read_en;
  assign bus.MemByteEnable  = be_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a small big-endian word memory with a
// registered Ack, directed load/store/error requests, and a monitor that
// checks every response pulse against the queued expectation.
module tb_mem_access_ctrl;

  logic CLK;
  logic RST;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  kind;      // one-hot {BusError, AddrError, RespValid}
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
    logic        chk_wd;
    logic [31:0] wd;
    int          en_cycles;
    int          stall_cycles;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:15];
  logic        ack_on;

  int          en_cycles;
  int          stall_cycles;
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;
  logic        seen_we;
  logic        unstable;

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the design never lets the bench finish.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endfunction

  function automatic exp_t mk(logic [2:0] kind, logic [31:0] data, logic [3:0] be,
                              logic we, logic chk_wd, logic [31:0] wd, int en, int st);
    exp_t e;
    e.kind = kind; e.data = data; e.be = be; e.we = we;
    e.chk_wd = chk_wd; e.wd = wd; e.en_cycles = en; e.stall_cycles = st;
    return e;
  endfunction

  // Memory model: combinational read while read-enabled, Ack one cycle after an enable.
  assign bus.MemReadData = bus.MemReadEnable ? mem[bus.MemAddress[5:2]] : 32'h0;

  always @(posedge CLK) begin
    if (RST) bus.MemAck <= 1'b0;
    else bus.MemAck <= ack_on && (bus.MemWriteEnable || bus.MemReadEnable) && !bus.MemAck;
  end

  always @(posedge CLK) begin
    if (bus.MemWriteEnable)
      for (int l = 0; l < 4; l++)
        if (bus.MemByteEnable[l])
          mem[bus.MemAddress[5:2]][8*l +: 8] <= bus.MemWriteData[8*l +: 8];
  end

  // Monitor: tally strobe/stall cycles per transaction and score each output pulse.
  always @(negedge CLK) begin
    if (RST) begin
      en_cycles = 0; stall_cycles = 0; unstable = 1'b0;
    end else begin
      if (bus.MemWriteEnable || bus.MemReadEnable) begin
        if (en_cycles == 0) begin
          seen_be = bus.MemByteEnable; seen_wd = bus.MemWriteData; seen_we = bus.MemWriteEnable;
        end else if (bus.MemByteEnable !== seen_be || bus.MemWriteData !== seen_wd) begin
          unstable = 1'b1;
        end
        en_cycles++;
      end
      if (bus.Stall) stall_cycles++;
      if (bus.RespValid || bus.AddrError || bus.BusError) begin
        if (exp_q.size() == 0) begin
          check_output("expected_entry_present", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("kind", {29'd0, bus.BusError, bus.AddrError, bus.RespValid}, {29'd0, e.kind});
          check_output("resp_data", bus.RespData, e.data);
          check_output("enable_cycles", 32'(en_cycles), 32'(e.en_cycles));
          check_output("stall_cycles", 32'(stall_cycles), 32'(e.stall_cycles));
          if (e.en_cycles != 0) begin
            check_output("byte_enable", {28'd0, seen_be}, {28'd0, e.be});
            check_output("write_strobe", {31'd0, seen_we}, {31'd0, e.we});
            check_output("bus_stable", {31'd0, unstable}, 32'd0);
            if (e.chk_wd) check_output("write_data", seen_wd, e.wd);
          end
        end
        en_cycles = 0; stall_cycles = 0; unstable = 1'b0;
      end
    end
  end

  // Present one request and hold it, like a frozen pipeline, until Stall drops or BusError.
  task automatic apply_stimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
    logic done;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.ReqSize = size;
    bus.ReqSigned = sgn; bus.ReqAddr = addr; bus.ReqWData = wdata;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (!bus.Stall || bus.BusError) done = 1'b1;
    end
    check_output("request_finished", {31'd0, done}, 32'd1);
    @(posedge CLK); #1;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 32'h0; bus.ReqWData = 32'h0;
  endtask

  localparam logic [2:0] K_RESP = 3'b001;
  localparam logic [2:0] K_ADDR = 3'b010;
  localparam logic [2:0] K_BUS  = 3'b100;

  // Main directed sequence.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    ack_on = 1'b1;
    en_cycles = 0; stall_cycles = 0; unstable = 1'b0;
    seen_be = 4'h0; seen_wd = 32'h0; seen_we = 1'b0;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 32'h0; bus.ReqWData = 32'h0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_output("reset_stall", {31'd0, bus.Stall}, 32'd0);
    check_output("reset_resp_valid", {31'd0, bus.RespValid}, 32'd0);
    check_output("reset_resp_data", bus.RespData, 32'h0);
    check_output("reset_enables", {30'd0, bus.MemWriteEnable, bus.MemReadEnable}, 32'd0);
    check_output("reset_mem_address", bus.MemAddress, 32'h0);
    check_output("reset_byte_enable", {28'd0, bus.MemByteEnable}, 32'd0);
    check_output("reset_write_data", bus.MemWriteData, 32'h0);

    // Word, byte and half accesses through the big-endian lanes
    apply_stimulus(1, 2'd2, 0, 32'h8, 32'hDEADBEEF, mk(K_RESP, 32'h0,        4'b1111, 1, 1, 32'hDEADBEEF, 2, 3));
    apply_stimulus(0, 2'd2, 0, 32'h8, 32'h0,        mk(K_RESP, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0,        2, 3));
    apply_stimulus(0, 2'd0, 1, 32'h9, 32'h0,        mk(K_RESP, 32'hFFFFFFAD, 4'b0100, 0, 0, 32'h0,        2, 3));
    apply_stimulus(0, 2'd0, 0, 32'hB, 32'h0,        mk(K_RESP, 32'h000000EF, 4'b0001, 0, 0, 32'h0,        2, 3));
    apply_stimulus(1, 2'd1, 0, 32'hA, 32'hABCD1234, mk(K_RESP, 32'h0,        4'b0011, 1, 1, 32'h12341234, 2, 3));
    apply_stimulus(0, 2'd2, 0, 32'h8, 32'h0,        mk(K_RESP, 32'hDEAD1234, 4'b1111, 0, 0, 32'h0,        2, 3));
    apply_stimulus(0, 2'd1, 1, 32'h8, 32'h0,        mk(K_RESP, 32'hFFFFDEAD, 4'b1100, 0, 0, 32'h0,        2, 3));
    apply_stimulus(0, 2'd1, 0, 32'hA, 32'h0,        mk(K_RESP, 32'h00001234, 4'b0011, 0, 0, 32'h0,        2, 3));
    apply_stimulus(1, 2'd0, 0, 32'hB, 32'h12345680, mk(K_RESP, 32'h0,        4'b0001, 1, 1, 32'h80808080, 2, 3));
    apply_stimulus(0, 2'd0, 1, 32'hB, 32'h0,        mk(K_RESP, 32'hFFFFFF80, 4'b0001, 0, 0, 32'h0,        2, 3));
    apply_stimulus(0, 2'd2, 1, 32'h8, 32'h0,        mk(K_RESP, 32'hDEAD1280, 4'b1111, 0, 0, 32'h0,        2, 3));

    // Misaligned and reserved-size requests
    apply_stimulus(0, 2'd2, 0, 32'h6, 32'h0,        mk(K_ADDR, 32'h0, 4'b0000, 0, 0, 32'h0, 0, 0));
    apply_stimulus(0, 2'd1, 1, 32'h3, 32'h0,        mk(K_ADDR, 32'h0, 4'b0000, 0, 0, 32'h0, 0, 0));
    apply_stimulus(0, 2'd3, 0, 32'h0, 32'h0,        mk(K_ADDR, 32'h0, 4'b0000, 0, 0, 32'h0, 0, 0));
    apply_stimulus(1, 2'd2, 0, 32'h9, 32'h11111111, mk(K_ADDR, 32'h0, 4'b0000, 0, 0, 32'h0, 0, 0));

    // Ack never arrives: 15 strobe cycles then a bus error
    ack_on = 1'b0;
    apply_stimulus(0, 2'd2, 0, 32'h0, 32'h0,        mk(K_BUS, 32'h0, 4'b1111, 0, 0, 32'h0, 15, 16));
    ack_on = 1'b1;

    // Reset during the first ACCESS cycle aborts silently
    @(posedge CLK); #1;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd2; bus.ReqAddr = 32'h8;
    @(posedge CLK); #1;
    check_output("abort_read_strobe_before", {31'd0, bus.MemReadEnable}, 32'd1);
    RST = 1'b1; bus.ReqValid = 1'b0; bus.ReqSize = 2'd0; bus.ReqAddr = 32'h0;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_output("abort_enables", {30'd0, bus.MemWriteEnable, bus.MemReadEnable}, 32'd0);
    check_output("abort_stall", {31'd0, bus.Stall}, 32'd0);
    check_output("abort_resp_valid", {31'd0, bus.RespValid}, 32'd0);
    apply_stimulus(0, 2'd2, 0, 32'h8, 32'h0,        mk(K_RESP, 32'hDEAD1280, 4'b1111, 0, 0, 32'h0, 2, 3));

    repeat (5) @(posedge CLK);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
